wb_regfile_commit: RTL and testbench

Write-back commit block at the consuming end of the DM/WB pipeline register. It takes the registered write-back bundle (halt, write enable, destination index, write data) and commits it to the 32×32 general-purpose register file. It provides two bypassed read ports to the decode stage and latches processor halt. It also keeps cycle and commit counters for the bench and debug logic.

---
 rtl/wb_regfile_commit.sv | 90 +++++++++
 tb/tb_wb_regfile_commit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile_commit.sv
// Write-back commit stage: commits the DM/WB bundle into the 32x32 register
// file, serves two write-first bypassed read ports to decode, latches halt,
// and keeps cycle and commit counters for debug.
module wb_regfile_commit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             halt_dm_wb,
  input  logic             regfile_w_en_dm_wb,
  input  logic [4:0]       regfile_req_w_dm_wb,
  input  logic [31:0]      regfile_data_w_dm_wb,
  input  logic [4:0]       regfile_req_a,
  input  logic [4:0]       regfile_req_b,
  output logic [31:0]      regfile_data_a,
  output logic [31:0]      regfile_data_b,
  output logic             halted,
  output logic             pipe_en,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] commit_count
);

  localparam logic ST_RUN    = 1'b0;
  localparam logic ST_HALTED = 1'b1;

  logic        state;
  logic        commit;
  logic [31:0] regs [32];

  // A write only lands while running and never to r0.
  assign commit = (state == ST_RUN) && regfile_w_en_dm_wb &&
                  (regfile_req_w_dm_wb != 5'd0);

  assign halted  = (state == ST_HALTED);
  assign pipe_en = ~halted;

  // Run/halt state; HALTED is left only through reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else if (state == ST_RUN && halt_dm_wb) begin
      state <= ST_HALTED;
    end
  end

  // Register array: cleared on reset, written on a committed write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'd0;
      end
    end else if (commit) begin
      regs[regfile_req_w_dm_wb] <= regfile_data_w_dm_wb;
    end
  end

  // Cycle and commit counters; both freeze once halted and wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_count  <= '0;
      commit_count <= '0;
    end else if (state == ST_RUN) begin
      cycle_count <= cycle_count + 1'b1;
      if (commit) begin
        commit_count <= commit_count + 1'b1;
      end
    end
  end

  // Read port A: r0 is zero, then write-first bypass, then the array.
  always_comb begin
    regfile_data_a = regs[regfile_req_a];
    if (regfile_req_a == 5'd0) begin
      regfile_data_a = 32'd0;
    end else if (commit && regfile_req_w_dm_wb == regfile_req_a) begin
      regfile_data_a = regfile_data_w_dm_wb;
    end
  end

  // Read port B: same priority as port A.
  always_comb begin
    regfile_data_b = regs[regfile_req_b];
    if (regfile_req_b == 5'd0) begin
      regfile_data_b = 32'd0;
    end else if (commit && regfile_req_w_dm_wb == regfile_req_b) begin
      regfile_data_b = regfile_data_w_dm_wb;
    end
  end

endmodule

// File: tb/tb_wb_regfile_commit.sv
// Directed self-checking bench for wb_regfile_commit. A second instance with
// 4-bit counters shares all inputs so counter wrap can be observed.
module tb_wb_regfile_commit;

  logic        clk;
  logic        rst_n;
  logic        halt_dm_wb;
  logic        regfile_w_en_dm_wb;
  logic [4:0]  regfile_req_w_dm_wb;
  logic [31:0] regfile_data_w_dm_wb;
  logic [4:0]  regfile_req_a;
  logic [4:0]  regfile_req_b;
  logic [31:0] regfile_data_a;
  logic [31:0] regfile_data_b;
  logic        halted;
  logic        pipe_en;
  logic [31:0] cycle_count;
  logic [31:0] commit_count;

  logic [31:0] data_a4;
  logic [31:0] data_b4;
  logic        halted4;
  logic        pipe_en4;
  logic [3:0]  cycle_count4;
  logic [3:0]  commit_count4;

  int checks;
  int errors;

  wb_regfile_commit #(.CNT_W(32)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .halt_dm_wb           (halt_dm_wb),
    .regfile_w_en_dm_wb   (regfile_w_en_dm_wb),
    .regfile_req_w_dm_wb  (regfile_req_w_dm_wb),
    .regfile_data_w_dm_wb (regfile_data_w_dm_wb),
    .regfile_req_a        (regfile_req_a),
    .regfile_req_b        (regfile_req_b),
    .regfile_data_a       (regfile_data_a),
    .regfile_data_b       (regfile_data_b),
    .halted               (halted),
    .pipe_en              (pipe_en),
    .cycle_count          (cycle_count),
    .commit_count         (commit_count)
  );

  wb_regfile_commit #(.CNT_W(4)) dut4 (
    .clk                  (clk),
    .rst_n                (rst_n),
    .halt_dm_wb           (halt_dm_wb),
    .regfile_w_en_dm_wb   (regfile_w_en_dm_wb),
    .regfile_req_w_dm_wb  (regfile_req_w_dm_wb),
    .regfile_data_w_dm_wb (regfile_data_w_dm_wb),
    .regfile_req_a        (regfile_req_a),
    .regfile_req_b        (regfile_req_b),
    .regfile_data_a       (data_a4),
    .regfile_data_b       (data_b4),
    .halted               (halted4),
    .pipe_en              (pipe_en4),
    .cycle_count          (cycle_count4),
    .commit_count         (commit_count4)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if it does not match.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Drive one cycle's worth of inputs and let combinational outputs settle.
  task automatic applyStimulus(input logic halt, input logic w_en,
                               input logic [4:0] req_w, input logic [31:0] data,
                               input logic [4:0] req_a, input logic [4:0] req_b);
    halt_dm_wb           = halt;
    regfile_w_en_dm_wb   = w_en;
    regfile_req_w_dm_wb  = req_w;
    regfile_data_w_dm_wb = data;
    regfile_req_a        = req_a;
    regfile_req_b        = req_b;
    #1;
  endtask

  // Advance past the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-edge reset pulse.
  task automatic pulseReset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    step();
    step();
    rst_n = 1'b1;

    // Reset clears the array.
    applyStimulus(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
    step();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
    checkOutput("r5_before_reset", regfile_data_a, 32'hDEADBEEF);
    pulseReset();
    #1;
    checkOutput("r5_after_reset", regfile_data_a, 32'd0);
    checkOutput("reset_cycle_count", cycle_count, 32'd0);
    checkOutput("reset_commit_count", commit_count, 32'd0);
    checkOutput("reset_halted", {31'd0, halted}, 32'd0);
    checkOutput("reset_pipe_en", {31'd0, pipe_en}, 32'd1);

    // Same-cycle bypass on both ports.
    applyStimulus(1'b0, 1'b1, 5'd7, 32'h12345678, 5'd7, 5'd7);
    checkOutput("bypass_a", regfile_data_a, 32'h12345678);
    checkOutput("bypass_b", regfile_data_b, 32'h12345678);
    step();
    applyStimulus(1'b0, 1'b0, 5'd7, 32'h0, 5'd7, 5'd7);
    checkOutput("array_a_r7", regfile_data_a, 32'h12345678);
    checkOutput("array_b_r7", regfile_data_b, 32'h12345678);
    checkOutput("commit_after_r7", commit_count, 32'd1);
    checkOutput("cycle_after_r7", cycle_count, 32'd1);

    // r0 protection.
    applyStimulus(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd7);
    checkOutput("r0_same_cycle", regfile_data_a, 32'd0);
    checkOutput("r7_untouched", regfile_data_b, 32'h12345678);
    step();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    checkOutput("r0_after", regfile_data_a, 32'd0);
    checkOutput("r0_not_counted", commit_count, 32'd1);

    // Reset beats a concurrent halt and write.
    applyStimulus(1'b1, 1'b1, 5'd4, 32'hCAFEF00D, 5'd4, 5'd7);
    pulseReset();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd4, 5'd7);
    checkOutput("rst_prio_halted", {31'd0, halted}, 32'd0);
    checkOutput("rst_prio_r4", regfile_data_a, 32'd0);
    checkOutput("rst_prio_r7", regfile_data_b, 32'd0);
    checkOutput("rst_prio_commit", commit_count, 32'd0);

    // Halt with a concurrent write after 10 RUN cycles.
    for (int i = 0; i < 10; i++) step();
    checkOutput("pre_halt_cycle", cycle_count, 32'd10);
    applyStimulus(1'b1, 1'b1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd0);
    checkOutput("halt_bypass_r3", regfile_data_a, 32'hA5A5A5A5);
    checkOutput("halt_pipe_en_still", {31'd0, pipe_en}, 32'd1);
    step();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd0);
    checkOutput("halted_set", {31'd0, halted}, 32'd1);
    checkOutput("halted_pipe_en", {31'd0, pipe_en}, 32'd0);
    checkOutput("halt_cycle_count", cycle_count, 32'd11);
    checkOutput("halt_commit_count", commit_count, 32'd1);
    checkOutput("halt_r3", regfile_data_a, 32'hA5A5A5A5);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 5'd3, 32'h1, 5'd3, 5'd0);
      checkOutput("halted_no_bypass", regfile_data_a, 32'hA5A5A5A5);
      step();
    end
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd0);
    checkOutput("halted_r3_kept", regfile_data_a, 32'hA5A5A5A5);
    checkOutput("halted_cycle_frozen", cycle_count, 32'd11);
    checkOutput("halted_commit_frozen", commit_count, 32'd1);

    // Reset out of HALTED.
    pulseReset();
    #1;
    checkOutput("unhalt_halted", {31'd0, halted}, 32'd0);
    checkOutput("unhalt_pipe_en", {31'd0, pipe_en}, 32'd1);
    checkOutput("unhalt_cycle", cycle_count, 32'd0);
    checkOutput("unhalt_commit", commit_count, 32'd0);
    applyStimulus(1'b0, 1'b1, 5'd9, 32'h55, 5'd0, 5'd0);
    step();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd3);
    checkOutput("r9_readback", regfile_data_a, 32'h55);
    checkOutput("r3_cleared", regfile_data_b, 32'd0);
    checkOutput("r9_commit", commit_count, 32'd1);

    // Counter wrap on the 4-bit instance.
    pulseReset();
    for (int i = 1; i <= 17; i++) begin
      applyStimulus(1'b0, 1'b1, 5'd1, 32'(i), 5'd0, 5'd0);
      step();
    end
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd1, 5'd0);
    checkOutput("wrap_cycle4", {28'd0, cycle_count4}, 32'd1);
    checkOutput("wrap_commit4", {28'd0, commit_count4}, 32'd1);
    checkOutput("wide_cycle", cycle_count, 32'd17);
    checkOutput("wide_commit", commit_count, 32'd17);
    checkOutput("wrap_r1", data_a4, 32'd17);
    checkOutput("wrap_pipe_en4", {31'd0, pipe_en4}, {31'd0, ~halted4});
    checkOutput("wrap_b4", data_b4, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
